// File: rtl/multi_pulse_prolongation.sv
// Multi-channel pulse stretcher with per-channel enable, prescale, retrigger and holdoff.
// Define PULSE_PROLONG_COUNTERS_EN to add per-channel emitted-pulse counters (count_clear, pulse_count).
//
// state   | meaning
// IDLE    | output low, waiting for an accepted rising edge
// ACTIVE  | output high, dcnt counts cycles since the last (re)start
// HOLDOFF | output low dead time, edges ignored, hcnt counts up to holdoff
module multi_pulse_prolongation #(
  parameter int CHANNELS   = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int SKIP_WIDTH = 8,
  parameter int HOLD_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CHANNELS-1:0]     signal,
  input  logic [CHANNELS-1:0]     enable,
  input  logic [LEN_WIDTH-1:0]    length,
  input  logic [SKIP_WIDTH-1:0]   skipsignals,
  input  logic [HOLD_WIDTH-1:0]   holdoff,
  input  logic                    retrigger,
`ifdef PULSE_PROLONG_COUNTERS_EN
  input  logic                    count_clear,
  output logic [CHANNELS*16-1:0]  pulse_count,
`endif
  output logic [CHANNELS-1:0]     longsignal
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  logic bypass;
  assign bypass = (length == '0);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  dcnt_q, dcnt_d;
    logic [HOLD_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [SKIP_WIDTH-1:0] skip_q, skip_d;
    logic                  last_q;
    logic                  rise;
    logic                  pass;

    assign rise = signal[i] & ~last_q;
    assign pass = (skip_q >= skipsignals);

    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      hcnt_d  = hcnt_q;
      skip_d  = skip_q;
      if (bypass || !enable[i]) begin
        state_d = IDLE;
        dcnt_d  = '0;
        hcnt_d  = '0;
        skip_d  = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rise) begin
              if (pass) begin
                skip_d  = '0;
                state_d = ACTIVE;
                dcnt_d  = LEN_WIDTH'(1);
              end else begin
                skip_d = skip_q + SKIP_WIDTH'(1);
              end
            end
          end
          ACTIVE: begin
            // an accepted retrigger edge restarts the duration and beats the exit test
            if (rise && retrigger && pass) begin
              skip_d = '0;
              dcnt_d = LEN_WIDTH'(1);
            end else begin
              if (rise && retrigger) skip_d = skip_q + SKIP_WIDTH'(1);
              if ((dcnt_q >= length) && !signal[i]) begin
                dcnt_d = '0;
                if (holdoff != '0) begin
                  state_d = HOLDOFF;
                  hcnt_d  = HOLD_WIDTH'(1);
                end else begin
                  state_d = IDLE;
                end
              end else if (dcnt_q != '1) begin
                dcnt_d = dcnt_q + LEN_WIDTH'(1);
              end
            end
          end
          HOLDOFF: begin
            if (hcnt_q >= holdoff) begin
              state_d = IDLE;
              hcnt_d  = '0;
            end else begin
              hcnt_d = hcnt_q + HOLD_WIDTH'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        dcnt_q  <= '0;
        hcnt_q  <= '0;
        skip_q  <= '0;
        last_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        hcnt_q  <= hcnt_d;
        skip_q  <= skip_d;
        last_q  <= signal[i];
      end
    end

    assign longsignal[i] = bypass ? signal[i] : (state_q == ACTIVE);

`ifdef PULSE_PROLONG_COUNTERS_EN
    logic [15:0] pcnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pcnt_q <= '0;
      end else if (count_clear) begin
        pcnt_q <= '0;
      end else if ((state_q == IDLE) && (state_d == ACTIVE) && (pcnt_q != 16'hFFFF)) begin
        pcnt_q <= pcnt_q + 16'd1;
      end
    end

    assign pulse_count[i*16 +: 16] = pcnt_q;
`endif
  end

endmodule

// File: tb/tb_multi_pulse_prolongation.sv
// Bench for multi_pulse_prolongation: directed scenarios plus random stimulus against a
// time-arithmetic reference model (elapsed cycles since start / since output end).
module tb_multi_pulse_prolongation;
  localparam int CH     = 4;
  localparam int M_IDLE = 0;
  localparam int M_ACT  = 1;
  localparam int M_HOLD = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] signal;
  logic [CH-1:0] enable;
  logic [7:0]    length;
  logic [7:0]    skipsignals;
  logic [7:0]    holdoff;
  logic          retrigger;
  logic [CH-1:0] longsignal;
`ifdef PULSE_PROLONG_COUNTERS_EN
  logic           count_clear;
  logic [CH*16-1:0] pulse_count;
  int             m_cnt[CH];
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  int m_mode[CH];
  int m_start[CH];
  int m_hstart[CH];
  int m_skip[CH];
  bit m_last[CH];
  int hi[CH];

  always #5 clk = ~clk;

  multi_pulse_prolongation dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .signal      (signal),
    .enable      (enable),
    .length      (length),
    .skipsignals (skipsignals),
    .holdoff     (holdoff),
    .retrigger   (retrigger),
`ifdef PULSE_PROLONG_COUNTERS_EN
    .count_clear (count_clear),
    .pulse_count (pulse_count),
`endif
    .longsignal  (longsignal)
  );

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_mode[c] = M_IDLE; m_start[c] = 0; m_hstart[c] = 0; m_skip[c] = 0; m_last[c] = 1'b0;
`ifdef PULSE_PROLONG_COUNTERS_EN
      m_cnt[c] = 0;
`endif
    end
  endfunction

  // One rising edge: output is high until `length` cycles have elapsed since the
  // last accepted edge and the input is low; then `holdoff` dead cycles follow.
  function automatic void model_step();
    for (int c = 0; c < CH; c++) begin
      automatic bit rise = signal[c] && !m_last[c];
      automatic bit started = 1'b0;
      if (length == 0 || !enable[c]) begin
        m_mode[c] = M_IDLE;
        m_skip[c] = 0;
      end else if (m_mode[c] == M_IDLE) begin
        if (rise) begin
          if (m_skip[c] >= int'(skipsignals)) begin
            m_skip[c] = 0; m_mode[c] = M_ACT; m_start[c] = cyc_n; started = 1'b1;
          end else m_skip[c]++;
        end
      end else if (m_mode[c] == M_ACT) begin
        if (rise && retrigger) begin
          if (m_skip[c] >= int'(skipsignals)) begin
            m_skip[c] = 0; m_start[c] = cyc_n;
          end else m_skip[c]++;
        end
        if ((cyc_n - m_start[c]) >= int'(length) && !signal[c]) begin
          m_mode[c]   = (holdoff != 0) ? M_HOLD : M_IDLE;
          m_hstart[c] = cyc_n;
        end
      end else begin
        if ((cyc_n - m_hstart[c]) >= int'(holdoff)) m_mode[c] = M_IDLE;
      end
      m_last[c] = signal[c];
`ifdef PULSE_PROLONG_COUNTERS_EN
      if (count_clear) m_cnt[c] = 0;
      else if (started && m_cnt[c] < 65535) m_cnt[c]++;
`else
      if (started) m_last[c] = signal[c];
`endif
    end
    cyc_n++;
  endfunction

  function automatic logic [CH-1:0] model_out();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = (length == 0) ? signal[c] : (m_mode[c] == M_ACT);
    return v;
  endfunction

  task automatic check_out(input string tag);
    logic [CH-1:0] e;
    e = model_out();
    n_cmp++;
    assert (longsignal === e) else begin
      n_err++;
      $error("FAIL %s: longsignal=%b expected %b at cycle %0d", tag, longsignal, e, cyc_n);
    end
    for (int c = 0; c < CH; c++) if (longsignal[c] === 1'b1) hi[c]++;
`ifdef PULSE_PROLONG_COUNTERS_EN
    for (int c = 0; c < CH; c++) begin
      n_cmp++;
      assert (pulse_count[c*16 +: 16] === 16'(m_cnt[c])) else begin
        n_err++;
        $error("FAIL %s_count%0d: pulse_count=%0d expected %0d", tag, c, pulse_count[c*16 +: 16], m_cnt[c]);
      end
    end
`endif
  endtask

  task automatic expect_int(input string tag, input int got, input int want);
    n_cmp++;
    assert (got == want) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    check_out("cycle");
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic pulse1(input int ch);
    signal[ch] = 1'b1;
    cyc();
    signal[ch] = 1'b0;
  endtask

  function automatic void clear_hi();
    for (int c = 0; c < CH; c++) hi[c] = 0;
  endfunction

  initial begin
    reset_n = 1'b0; signal = '0; enable = '1; length = 8'd0;
    skipsignals = 8'd0; holdoff = 8'd0; retrigger = 1'b0;
`ifdef PULSE_PROLONG_COUNTERS_EN
    count_clear = 1'b0;
`endif
    model_reset();
    clear_hi();

    #1 check_out("bypass_in_reset");
    signal = 4'b1010; #1 check_out("bypass_in_reset");
    signal = 4'b0101; #1 check_out("bypass_in_reset");
    signal = '0; length = 8'd5; #1 check_out("reset_state");
    @(negedge clk);
    reset_n = 1'b1;

    // 1-cycle pulse, length 5
    clear_hi();
    pulse1(0); idle(10);
    expect_int("len5_width", hi[0], 5);
    expect_int("len5_others", hi[1] + hi[2] + hi[3], 0);

    // long input, length 3
    length = 8'd3; clear_hi();
    signal[1] = 1'b1; idle(10); signal[1] = 1'b0; idle(5);
    expect_int("long_input_width", hi[1], 10);

    // prescale: only pulses 3 and 6 emitted
    length = 8'd4; skipsignals = 8'd2; clear_hi();
    for (int p = 0; p < 6; p++) begin pulse1(2); idle(19); end
    expect_int("skip2_width", hi[2], 8);
    skipsignals = 8'd0;

    // retrigger on / off
    length = 8'd8; retrigger = 1'b1; clear_hi();
    pulse1(3); idle(4); pulse1(3); idle(20);
    expect_int("retrig_on_width", hi[3], 13);
    retrigger = 1'b0; clear_hi();
    pulse1(3); idle(4); pulse1(3); idle(20);
    expect_int("retrig_off_width", hi[3], 8);

    // holdoff swallows an edge, later edge is emitted
    length = 8'd2; holdoff = 8'd6; clear_hi();
    pulse1(0); idle(3); pulse1(0); idle(5);
    expect_int("holdoff_single", hi[0], 2);
    pulse1(0); idle(10);
    expect_int("holdoff_after", hi[0], 4);
    holdoff = 8'd0;

    // simultaneous edges on all channels
    length = 8'd3; clear_hi();
    signal = 4'b1111; cyc(); signal = '0; idle(6);
    expect_int("simultaneous", hi[0] + hi[1] + hi[2] + hi[3], 12);

    // disabled channel emits nothing
    enable = 4'b1101; clear_hi();
    pulse1(1); idle(8);
    expect_int("disabled", hi[1], 0);
    enable = '1;

    // bypass follows the input with zero latency
    length = 8'd0;
    for (int k = 0; k < 6; k++) begin
      signal = 4'($urandom_range(0, 15));
      #1 check_out("bypass_comb");
      cyc();
    end
    signal = '0;

    // asynchronous reset while ACTIVE, then a fresh 6-cycle pulse
    length = 8'd6;
    cyc();
    pulse1(0); idle(2);
    reset_n = 1'b0;
    #1 model_reset(); check_out("reset_mid_active");
    expect_int("reset_mid_active_low", int'(longsignal[0]), 0);
    length = 8'd0; signal = 4'b0011;
    #1 check_out("bypass_in_reset2");
    signal = '0; length = 8'd6;
    cyc();
    reset_n = 1'b1;
    clear_hi();
    pulse1(0); idle(10);
    expect_int("after_reset_width", hi[0], 6);

    // random stimulus against the model
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 59) == 0)
        length = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
      if ($urandom_range(0, 59) == 0) skipsignals = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) holdoff = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 39) == 0) retrigger = ~retrigger;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 79) == 0) enable[c] = ~enable[c];
        if (signal[c]) signal[c] = 1'($urandom_range(0, 1));
        else signal[c] = ($urandom_range(0, 5) == 0);
      end
`ifdef PULSE_PROLONG_COUNTERS_EN
      count_clear = ($urandom_range(0, 99) == 0);
`endif
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multi_pulse_prolongation.md
Name: multi_pulse_prolongation

Overview:
- Multi-channel, parametrised pulse stretcher for passing short strobes from a fast clock domain to slower consumers.
- Each channel lengthens an input pulse to a minimum of `length` clock cycles.
- Adds per-channel enable, an optional retrigger (extend) mode, a post-pulse holdoff (dead time) and 1-of-N prescaling.
- Sits between hit/strobe sources and slow-clock readout or trigger logic.

Parameters:
- CHANNELS, 4, number of independent channels.
- LEN_WIDTH, 8, width of `length` and of the per-channel duration counter.
- SKIP_WIDTH, 8, width of `skipsignals` and of the per-channel prescale counter.
- HOLD_WIDTH, 8, width of `holdoff` and of the per-channel holdoff counter.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- signal  in  CHANNELS  input pulses, one bit per channel.
- enable  in  CHANNELS  per-channel enable.
- length  in  LEN_WIDTH  minimum output duration in cycles; 0 = bypass.
- skipsignals  in  SKIP_WIDTH  number of accepted-candidate edges dropped between emitted pulses.
- holdoff  in  HOLD_WIDTH  dead-time cycles after each output pulse.
- retrigger  in  1  1 = an accepted edge during ACTIVE restarts the duration.
- longsignal  out  CHANNELS  prolonged pulses.

Behaviour:
- Reset (reset_n low, asynchronous): all states go to IDLE; all counters, edge-detect registers and registered outputs clear to 0.
- Bypass: when length==0, longsignal = signal combinationally on all channels, including during reset. In that case, state is forced to IDLE and counters are held at 0.
- Edge detect: rise[i] = signal[i] & ~last[i], where last[i] is signal registered.
- Prescale: on rise[i] in IDLE (or in ACTIVE with retrigger=1):
  - if skipcnt[i] >= skipsignals, the edge is accepted and skipcnt is cleared to 0;
  - otherwise skipcnt increments and the edge is rejected.
  - With skipsignals=0, every edge is accepted. With skipsignals=2, edges 3, 6, 9, ... after reset are accepted.
- States per channel:
  - IDLE: longsignal=0. An accepted edge goes to ACTIVE, sets dcnt=1 and drives longsignal=1 from the next cycle (latency 1 cycle).
  - ACTIVE: longsignal=1 and dcnt increments, saturating at all-ones.
    - Exit when dcnt >= length && !signal[i]. longsignal drops the next cycle.
    - Go to HOLDOFF if holdoff != 0 (hcnt=1), else to IDLE.
    - With retrigger=1, an accepted edge in ACTIVE sets dcnt=1; this takes priority over exit.
    - With retrigger=0, edges in ACTIVE are ignored and do not advance skipcnt.
  - HOLDOFF: longsignal=0. Edges are ignored and do not advance skipcnt. hcnt increments each cycle; return to IDLE when hcnt >= holdoff.
- Resulting pulse widths: a 1-cycle input gives exactly `length` output cycles. An input longer than `length` gives an output that ends 1 cycle after the input falls.
- Enable: enable[i]=0 forces IDLE, longsignal[i]=0 and clears dcnt, hcnt and skipcnt next cycle. It is overridden by bypass.
- Config changes (length, holdoff, skipsignals) mid-pulse take effect on the next comparison, with no glitch beyond the exit rules above.
- Channels are fully independent; simultaneous edges on any set of channels are all handled in the same cycle.

Optional Feature:
- Macro: PULSE_PROLONG_COUNTERS_EN
- Defined: adds two ports.
  - count_clear  in  1: synchronous clear of all counts.
  - pulse_count  out  CHANNELS*16: per-channel count of emitted pulses (IDLE->ACTIVE transitions), saturating at 16'hFFFF.
  - Retriggers are not counted. Counts reset to 0 on reset_n. count_clear takes priority over a same-cycle increment.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- length=5, skip=0, holdoff=0, 1-cycle pulse on ch0 -> longsignal[0] high for exactly 5 cycles, starting 1 cycle after the input; other channels stay 0.
- length=3, 10-cycle input pulse on ch1 -> output high for 10 cycles, starting 1 cycle after the input rises and falling 1 cycle after the input falls.
- skip=2, six 1-cycle pulses spaced 20 cycles, length=4 -> only pulses 3 and 6 are emitted, each 4 cycles long.
- length=8, retrigger=1, pulses at t=0 and t=5 -> output continuous for 13 cycles. Same stimulus with retrigger=0 -> 8 cycles, and the second edge is ignored.
- length=2, holdoff=6, pulses at t=0 and t=4 -> a single 2-cycle output; a pulse at t=10 is emitted.
- length=0 -> longsignal equals signal with zero latency, including while reset_n=0. reset_n asserted mid-ACTIVE with length=6 -> output immediately 0. After release, the next pulse is 6 cycles long.
